// File: rtl/store_buffer.sv
// store_buffer: in-order buffer of finished stores, drained to memory after ROB commit,
// with youngest-match store-to-load forwarding. Define SB_PERFCNT_EN to add sb_fullstall_cnt.
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef SPECTAG_LEN
`define SPECTAG_LEN 5
`endif

module store_buffer #(
  parameter int SB_SEL   = 3,
  parameter int SB_DEPTH = 8,
  parameter int DATA_W   = `DATA_LEN,
  parameter int ADDR_W   = `ADDR_LEN,
  parameter int SPEC_W   = `SPECTAG_LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stfin,
  input  logic [ADDR_W-1:0] storeaddr,
  input  logic [DATA_W-1:0] storedata,
  input  logic              stspecbit,
  input  logic [SPEC_W-1:0] stspectag,
  input  logic              prmiss,
  input  logic              prsuccess,
  input  logic [SPEC_W-1:0] spectagfix,
  input  logic [1:0]        stcom,
  input  logic              memoccupy_ld,
  output logic              fullsb,
  input  logic [ADDR_W-1:0] ldaddr,
  output logic              hitsb,
  output logic [DATA_W-1:0] lddatasb,
  output logic              memwe,
  output logic [ADDR_W-1:0] memaddr,
`ifdef SB_PERFCNT_EN
  output logic [31:0]       sb_fullstall_cnt,
`endif
  output logic [DATA_W-1:0] memdata
);

  localparam int PW = SB_SEL + 1;
  typedef logic [PW-1:0] ptr_t;

  logic [ADDR_W-1:0] addr_q    [SB_DEPTH];
  logic [DATA_W-1:0] data_q    [SB_DEPTH];
  logic [SPEC_W-1:0] spectag_q [SB_DEPTH];
  logic [SB_DEPTH-1:0] valid_q, specbit_q, valid_d, specbit_d, kill;

  ptr_t head_q, comptr_q, tail_q;
  ptr_t count, nkill;
  logic [SB_SEL-1:0] head_idx, tail_idx, fwd_idx;
  logic incoming_match, alloc, drain, alloc_spec;

  assign head_idx = head_q[SB_SEL-1:0];
  assign tail_idx = tail_q[SB_SEL-1:0];
  assign count    = tail_q - head_q;
  assign fullsb   = (count == ptr_t'(SB_DEPTH));

  // A store resolving in the same cycle as its branch sees that resolution immediately.
  assign incoming_match = |(stspectag & spectagfix);
  assign alloc      = stfin & ~fullsb & ~(prmiss & incoming_match);
  assign alloc_spec = stspecbit & ~(prsuccess & incoming_match);

  assign drain   = ~memoccupy_ld & (head_q != comptr_q);
  assign memwe   = drain;
  assign memaddr = drain ? addr_q[head_idx] : '0;
  assign memdata = drain ? data_q[head_idx] : '0;

  // NOTE: every variable driven here gets a default first so no latch can be inferred.
  always_comb begin
    kill      = '0;
    nkill     = '0;
    valid_d   = valid_q;
    specbit_d = specbit_q;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (prmiss && valid_q[i] && specbit_q[i] && |(spectag_q[i] & spectagfix)) begin
        kill[i]    = 1'b1;
        valid_d[i] = 1'b0;
        nkill      = nkill + ptr_t'(1);
      end
      if (prsuccess && |(spectag_q[i] & spectagfix))
        specbit_d[i] = 1'b0;
    end
    if (drain)
      valid_d[head_idx] = 1'b0;
    if (alloc) begin
      valid_d[tail_idx]   = 1'b1;
      specbit_d[tail_idx] = alloc_spec;
    end
  end

  // Walk oldest to youngest so the last match found is the one nearest the tail.
  always_comb begin
    hitsb    = 1'b0;
    lddatasb = '0;
    fwd_idx  = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      fwd_idx = head_idx + SB_SEL'(k);
      if (valid_q[fwd_idx] && addr_q[fwd_idx] == ldaddr) begin
        hitsb    = 1'b1;
        lddatasb = data_q[fwd_idx];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q    <= '0;
      comptr_q  <= '0;
      tail_q    <= '0;
      valid_q   <= '0;
      specbit_q <= '0;
    end else begin
      head_q    <= head_q + ptr_t'(drain);
      comptr_q  <= comptr_q + ptr_t'(stcom);
      tail_q    <= tail_q + ptr_t'(alloc) - nkill;
      valid_q   <= valid_d;
      specbit_q <= specbit_d;
    end
  end

  // NOTE: payload storage has no reset; valid_q alone decides whether an entry means anything.
  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[tail_idx]    <= storeaddr;
      data_q[tail_idx]    <= storedata;
      spectag_q[tail_idx] <= stspectag;
    end
  end

`ifdef SB_PERFCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      sb_fullstall_cnt <= '0;
    else if (stfin && fullsb && sb_fullstall_cnt != 32'hFFFF_FFFF)
      sb_fullstall_cnt <= sb_fullstall_cnt + 32'd1;
  end
`endif

  a_no_stfin_when_full: assert property (@(posedge clk) disable iff (!reset)
    !(stfin && fullsb));
  a_commit_in_range: assert property (@(posedge clk) disable iff (!reset)
    ptr_t'(stcom) <= ptr_t'(tail_q - comptr_q));
  a_no_miss_and_success: assert property (@(posedge clk) disable iff (!reset)
    !(prmiss && prsuccess));

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: queue-model scoreboard checked every cycle, plus directed sequences
// and a table of forwarding lookups for store_buffer.
module tb_store_buffer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stfin, stspecbit, prmiss, prsuccess, memoccupy_ld;
  logic [AW-1:0] storeaddr, ldaddr, memaddr;
  logic [DW-1:0] storedata, lddatasb, memdata;
  logic [SW-1:0] stspectag, spectagfix;
  logic [1:0]    stcom;
  logic          fullsb, hitsb, memwe;
`ifdef SB_PERFCNT_EN
  logic [31:0]   sb_fullstall_cnt;
`endif

  always #5 clk = ~clk;

  store_buffer #(.SB_SEL(3), .SB_DEPTH(8), .DATA_W(DW), .ADDR_W(AW), .SPEC_W(SW)) dut (
    .clk(clk), .reset(reset), .stfin(stfin), .storeaddr(storeaddr), .storedata(storedata),
    .stspecbit(stspecbit), .stspectag(stspectag), .prmiss(prmiss), .prsuccess(prsuccess),
    .spectagfix(spectagfix), .stcom(stcom), .memoccupy_ld(memoccupy_ld), .fullsb(fullsb),
    .ldaddr(ldaddr), .hitsb(hitsb), .lddatasb(lddatasb), .memwe(memwe), .memaddr(memaddr),
`ifdef SB_PERFCNT_EN
    .sb_fullstall_cnt(sb_fullstall_cnt),
`endif
    .memdata(memdata));

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          spec;
    logic [SW-1:0] tag;
  } ent_t;

  typedef struct {
    logic [AW-1:0] ld;
    logic          hit;
    logic [DW-1:0] data;
  } fwd_vec_t;

  ent_t sbq[$];      // oldest at index 0
  int   ncom = 0;    // leading entries of sbq already committed
  int   nchecks = 0;
  int   nerr = 0;
  int   drains_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare against the model in the stable part of the cycle, then advance the model
  // by the effect of the coming edge.
  task automatic model_step();
    logic          exp_full, exp_we, exp_hit, push;
    logic [DW-1:0] exp_ld;
    ent_t          e;
    exp_full = (sbq.size() == 8);
    exp_we   = !memoccupy_ld && ncom > 0;
    exp_hit  = 1'b0;
    exp_ld   = '0;
    foreach (sbq[i])
      if (sbq[i].addr == ldaddr) begin
        exp_hit = 1'b1;
        exp_ld  = sbq[i].data;
      end
    check("mon_fullsb", fullsb, exp_full);
    check("mon_memwe", memwe, exp_we);
    check("mon_hitsb", hitsb, exp_hit);
    check("mon_lddatasb", lddatasb, exp_ld);
    if (exp_we) begin
      check("mon_memaddr", memaddr, sbq[0].addr);
      check("mon_memdata", memdata, sbq[0].data);
    end else begin
      check("mon_memaddr_idle", memaddr, 0);
      check("mon_memdata_idle", memdata, 0);
    end
    push   = stfin && !exp_full && !(prmiss && (stspectag & spectagfix) != 0);
    e.addr = storeaddr;
    e.data = storedata;
    e.spec = stspecbit && !(prsuccess && (stspectag & spectagfix) != 0);
    e.tag  = stspectag;
    if (prsuccess)
      foreach (sbq[i])
        if ((sbq[i].tag & spectagfix) != 0) sbq[i].spec = 1'b0;
    if (prmiss)
      for (int i = sbq.size() - 1; i >= ncom; i--)
        if (sbq[i].spec && (sbq[i].tag & spectagfix) != 0) sbq.delete(i);
    ncom += int'(stcom);
    if (exp_we) begin
      void'(sbq.pop_front());
      ncom--;
      drains_seen++;
    end
    if (push) sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      sbq.delete();
      ncom = 0;
    end else begin
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic sp, input logic [SW-1:0] tg);
    stfin     = 1'b1;
    storeaddr = a;
    storedata = d;
    stspecbit = sp;
    stspectag = tg;
    tick();
    stfin     = 1'b0;
    stspecbit = 1'b0;
    stspectag = '0;
  endtask

  task automatic lookup(input string name, input logic [AW-1:0] a,
                        input logic exp_hit, input logic [DW-1:0] exp_data);
    ldaddr = a;
    #1;
    check({name, "_hit"}, hitsb, exp_hit);
    check({name, "_data"}, lddatasb, exp_data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fwd_vec_t fwd_tab[5];
    int d0, left;
    fwd_tab[0] = '{32'h40, 1'b1, 32'd2};
    fwd_tab[1] = '{32'h44, 1'b0, 32'd0};
    fwd_tab[2] = '{32'h80, 1'b1, 32'd3};
    fwd_tab[3] = '{32'hC0, 1'b1, 32'd4};
    fwd_tab[4] = '{32'h00, 1'b0, 32'd0};

    stfin = 0; storeaddr = '0; storedata = '0; stspecbit = 0; stspectag = '0;
    prmiss = 0; prsuccess = 0; spectagfix = '0; stcom = '0; memoccupy_ld = 0; ldaddr = '0;
    #1 reset = 1'b0;
    #1;
    check("rst_fullsb", fullsb, 0);
    check("rst_memwe", memwe, 0);
    check("rst_hitsb", hitsb, 0);
    check("rst_lddatasb", lddatasb, 0);
    check("rst_memaddr", memaddr, 0);
    check("rst_memdata", memdata, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // Reset in the middle of a cycle with live entries
    store(32'h10, 32'h11, 0, 0);
    store(32'h14, 32'h22, 0, 0);
    store(32'h18, 32'h33, 0, 0);
    stcom = 1; tick(); stcom = 0;
    ldaddr = 32'h10;
    #1;
    check("midrst_memwe_before", memwe, 1);
    check("midrst_hitsb_before", hitsb, 1);
    #1 reset = 1'b0;
    #1;
    check("midrst_fullsb", fullsb, 0);
    check("midrst_memwe", memwe, 0);
    check("midrst_hitsb", hitsb, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    lookup("midrst_after", 32'h10, 0, 0);
    tick();

    // Basic store -> commit -> drain
    store(32'h100, 32'hAA, 0, 0);
    stcom = 1; tick(); stcom = 0;
    #1;
    check("basic_memwe", memwe, 1);
    check("basic_memaddr", memaddr, 32'h100);
    check("basic_memdata", memdata, 32'hAA);
    tick();
    check("basic_memwe_after", memwe, 0);
    lookup("basic_empty", 32'h100, 0, 0);

    // Youngest-match forwarding, table driven
    store(32'h40, 32'd1, 0, 0);
    store(32'h40, 32'd2, 0, 0);
    store(32'h80, 32'd3, 0, 0);
    store(32'hC0, 32'd4, 0, 0);
    for (int i = 0; i < 5; i++) begin
      lookup($sformatf("fwd_tab%0d", i), fwd_tab[i].ld, fwd_tab[i].hit, fwd_tab[i].data);
      tick();
    end
    stcom = 1; tick(); stcom = 0;
    check("fwd_draining_memwe", memwe, 1);
    lookup("fwd_during_drain", 32'h40, 1, 32'd2);
    tick();
    lookup("fwd_after_drain", 32'h40, 1, 32'd2);
    lookup("fwd_miss_44", 32'h44, 0, 0);
    stcom = 2; tick(); stcom = 1; tick(); stcom = 0;
    repeat (4) tick();

    // Fill, drain with a contended memory port, and go round the index space twice
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 8; i++)
        store(32'h200 + 32'(rep * 'h100 + i * 4), 32'(32'h1000 * (rep + 1) + i), 0, 0);
      #1;
      check($sformatf("full_set_rep%0d", rep), fullsb, 1);
      tick();
      check($sformatf("full_hold_rep%0d", rep), fullsb, 1);
      d0 = drains_seen;
      for (int j = 0; j < 4; j++) begin
        stcom = 2;
        memoccupy_ld = (j % 2 == 0);
        tick();
      end
      stcom = 0;
      memoccupy_ld = 0;
      check($sformatf("full_drains_rep%0d", rep), 32'(drains_seen - d0), 2);
      repeat (7) tick();
      check($sformatf("full_empty_rep%0d", rep), 32'(sbq.size()), 0);
    end

    // Mispredict kills the speculative young end
    store(32'h300, 32'hA0, 0, 5'b00000);
    store(32'h304, 32'hB0, 1, 5'b00001);
    store(32'h308, 32'hC0, 1, 5'b00001);
    prmiss = 1; spectagfix = 5'b00001; tick(); prmiss = 0; spectagfix = '0;
    lookup("miss_b_gone", 32'h304, 0, 0);
    lookup("miss_c_gone", 32'h308, 0, 0);
    lookup("miss_a_kept", 32'h300, 1, 32'hA0);
    stcom = 1; tick(); stcom = 0;
    #1;
    check("miss_drain_a_we", memwe, 1);
    check("miss_drain_a_addr", memaddr, 32'h300);
    tick();
    check("miss_nothing_left", memwe, 0);
    store(32'h30C, 32'hD0, 0, 0);
    stcom = 1; tick(); stcom = 0;
    #1;
    check("miss_rollback_addr", memaddr, 32'h30C);
    check("miss_rollback_data", memdata, 32'hD0);
    tick();

    // prsuccess clears speculation, including for a store arriving that same edge
    store(32'h400, 32'hE0, 1, 5'b00010);
    stfin = 1; storeaddr = 32'h404; storedata = 32'hF0; stspecbit = 1; stspectag = 5'b00010;
    prsuccess = 1; spectagfix = 5'b00010;
    tick();
    stfin = 0; stspecbit = 0; stspectag = '0; prsuccess = 0;
    prmiss = 1; tick(); prmiss = 0; spectagfix = '0;
    lookup("succ_e_kept", 32'h400, 1, 32'hE0);
    lookup("succ_f_kept", 32'h404, 1, 32'hF0);
    stcom = 1; tick();
    #1;
    check("succ_drain_e", memaddr, 32'h400);
    tick(); stcom = 0;
    #1;
    check("succ_drain_f", memaddr, 32'h404);
    repeat (2) tick();

    // Random mix of allocate, commit, drain and forwarding
    for (int c = 0; c < 300; c++) begin
      left         = sbq.size() - ncom;
      stfin        = (sbq.size() < 8) && ($urandom_range(0, 2) != 0);
      storeaddr    = 32'h500 + 32'($urandom_range(0, 7) * 4);
      storedata    = $urandom;
      stcom        = 2'($urandom_range(0, 2) < left ? $urandom_range(0, 2) : left);
      if (int'(stcom) > left) stcom = 2'(left);
      memoccupy_ld = ($urandom_range(0, 3) == 0);
      ldaddr       = 32'h500 + 32'($urandom_range(0, 7) * 4);
      tick();
    end
    stfin = 0;
    memoccupy_ld = 0;
    for (int c = 0; c < 20 && ncom < sbq.size(); c++) begin
      left  = sbq.size() - ncom;
      stcom = 2'(left > 2 ? 2 : left);
      tick();
    end
    stcom = 0;
    repeat (10) tick();
    check("end_empty", 32'(sbq.size()), 0);
    check("end_memwe", memwe, 0);
`ifdef SB_PERFCNT_EN
    check("perfcnt_no_stalls", sb_fullstall_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end
endmodule
